// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver/transmitter state encoding,
//                data width and the bit-period helper used by both directions.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  // System clocks per serial bit; integer truncation is intentional.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : CPU-side holding-register interface of the UART receiver.
//                master = CPU/iobus side, slave = receiver side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rd_en;
  logic                 err_clr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rd_en, err_clr,
    input  rx_data, rx_valid, frame_err, overrun
  );

  modport slave (
    input  rd_en, err_clr,
    output rx_data, rx_valid, frame_err, overrun
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for an asynchronous single-bit input.
//                Both flops preset to RESET_VAL so the output shows the
//                line's idle level straight out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic r_meta;

  // Two-stage capture; r_meta may go metastable, q is the settled copy.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_meta <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with one-entry holding register,
//                valid/ack handshake and sticky framing/overrun status.
//                Define UART_RX_PARITY_EN for 8E1 framing with even-parity
//                checking (a parity mismatch reports as a framing error).
//                CLKS_PER_BIT must be at least 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic      clk,
  input  logic      n_reset,
  input  logic      rxd,
  uart_rx_if.slave  bus
);
  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int c_cnt_w      = $clog2(CLKS_PER_BIT);
  localparam int c_idx_w      = $clog2(DATA_BITS);

  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rxs;
  logic                 w_tick;
  logic                 w_load_half;
  logic                 w_shift;
  logic                 w_commit;
  logic                 w_set_ferr;
  logic                 w_set_ovr;
  logic                 w_par_err;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (rxd),
    .q       (w_rxs)
  );

  assign w_tick = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
  logic w_par_chk;
  logic w_par_bad;
  logic r_par_err;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_bad = ^{r_shift, w_rxs};
  assign w_par_err = r_par_err;

  // Remember a parity mismatch so the following STOP discards the byte.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)       r_par_err <= 1'b0;
    else if (w_par_chk) r_par_err <= w_par_bad;
  end
`else
  assign w_par_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_half = 1'b0;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    w_set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_chk   = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = ST_START;
          w_load_half = 1'b1;
        end
      end
      ST_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (w_tick) w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_idx == c_last_idx) w_state_nxt = ST_PARITY;
`else
          if (r_idx == c_last_idx) w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_par_chk   = 1'b1;
          w_set_ferr  = w_par_bad;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (!w_rxs) begin
            w_set_ferr  = 1'b1;
            w_state_nxt = ST_WAIT_HIGH;
          end else begin
            w_commit    = !w_par_err;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line (break) must not retrigger a frame.
        if (w_rxs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit-period counter: half period into the start bit, then full periods.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      r_cnt <= '0;
    else if (w_load_half)
      r_cnt <= c_cnt_half;
    else if (r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
      r_cnt <= w_tick ? c_cnt_full : r_cnt - 1'b1;
  end

  // Bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      if (r_state == ST_START) r_idx <= '0;
      else if (w_shift)        r_idx <= r_idx + 1'b1;
      if (w_shift) r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
    end
  end

  assign w_set_ovr = w_commit && bus.rx_valid && !bus.rd_en;

  // Holding register: a commit with a same-cycle ack replaces the byte.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
    end else if (w_commit && (!bus.rx_valid || bus.rd_en)) begin
      bus.rx_data  <= r_shift;
      bus.rx_valid <= 1'b1;
    end else if (bus.rd_en && !w_commit) begin
      bus.rx_valid <= 1'b0;
    end
  end

  // Sticky status flags; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (w_set_ferr)       bus.frame_err <= 1'b1;
      else if (bus.err_clr) bus.frame_err <= 1'b0;
      if (w_set_ovr)        bus.overrun   <= 1'b1;
      else if (bus.err_clr) bus.overrun   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the txd transmitter on the iobus.
- Samples asynchronous rxd, reassembles bytes LSB-first, and presents them in a one-entry holding register with a valid/ack handshake.
- Sticky framing and overrun status.
- Sits beside the transmitter inside the iobus; the CPU polls rx_valid and reads rx_data.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (local, derived), clocks per bit period. Must be ≥ 4.

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_reset  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- rd_en  input  1  one-cycle read acknowledge; consumes the held byte.
- err_clr  input  1  one-cycle clear of frame_err and overrun.
- rx_data  output  8  last received byte.
- rx_valid  output  1  holding register contains an unread byte.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte completed while rx_valid=1 and not acknowledged.

Behaviour:
- Reset (async, n_reset=0):
  - All outputs 0; FSM enters IDLE; counters 0.
  - Both synchronizer flops preset to 1 (line idle).
  - Reset mid-frame abandons the frame with no partial data.
- Input path: rxd passes through a 2-flop synchronizer. All FSM decisions use the synchronized value rxs (2-cycle input latency).
- bit_cnt counts CLKS_PER_BIT-1 down to 0; tick when it reaches 0, then it reloads.
- FSM states:
  - IDLE: rxs=0 → START, cnt loaded with CLKS_PER_BIT/2-1 (integer divide).
  - START: on tick, sample rxs.
    - 1 → IDLE (glitch rejected, no flag).
    - 0 → DATA, bit index=0.
  - DATA: on each tick, shift rxs into bit[index], LSB first. After index 7 → PARITY if enabled, else STOP.
  - PARITY (optional feature only): on tick, compare; → STOP.
  - STOP: on tick, sample rxs.
    - 1 and no error → commit the byte.
    - 0 → frame_err<=1, byte discarded, → WAIT_HIGH.
    - Otherwise → IDLE.
  - WAIT_HIGH: stay until rxs=1 (break/line-low handling), then → IDLE. Prevents a held-low line from retriggering every frame.
- Commit (in the clock of the stop-bit tick):
  - rx_valid=0, or rd_en=1 in the same cycle → rx_data<=byte, rx_valid<=1. Simultaneous ack and commit: new byte loaded, rx_valid stays 1, no overrun.
  - rx_valid=1 and rd_en=0 → byte dropped, rx_data unchanged, overrun<=1.
- rd_en with no commit: rx_valid<=0 next cycle. rx_data holds its value.
- rd_en with rx_valid=0: no effect.
- err_clr clears both sticky flags. If a flag-setting event occurs in the same cycle, the set wins.
- Latency: rx_valid rises one clock after the stop-bit mid-sample. That is about 9.5 bit times plus 3 clocks after the falling start edge on rxd.
- The FSM accepts a new start bit immediately from IDLE after STOP, so back-to-back frames are supported.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Frame is 8E1; a PARITY state is added after bit 7.
  - Even parity check: a mismatch sets frame_err and discards the byte (the STOP state is still traversed).
- Undefined: 8N1, no PARITY state, no parity logic.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - the DATA_BITS=8 constant;
  - a function computing CLKS_PER_BIT. The transmitter reuses it.
- One natural sub-module: sync2, the 2-flop synchronizer with a preset-on-reset value parameter. Everything else stays in uart_rx.

Test Plan:
- Bench setup: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clks/bit).
- Send 0xA5 8N1 → rx_valid=1 with rx_data=0xA5 about 95 clks after the start edge; frame_err=0. Pulse rd_en → rx_valid=0 next cycle.
- 3-clock low glitch on rxd while idle → no rx_valid, FSM back in IDLE, no flags.
- Send 0x3C with the stop bit driven 0, then hold rxd low 30 bit times → frame_err=1, rx_valid=0, no further frames decoded until rxd returns high. err_clr → frame_err=0.
- Send 0x11 then 0x22 with no rd_en → rx_data=0x11, overrun=1. Send 0x33 with rd_en on its commit cycle → rx_data=0x33, rx_valid=1, overrun unchanged.
- Drop n_reset in mid-DATA of 0xFF, release, send 0x5A → only 0x5A received; all outputs 0 during reset.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 → rx_data=0x07. Send it with parity bit 0 → frame_err=1, no rx_valid.
